// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Qualifies the PLL lock flag and sequences the downstream reset and ready
// status for the pixel-clock domain. Lock must be seen continuously for
// STABLE_CYCLES, then reset is held for HOLD_CYCLES more before RUN.
// Losing lock in RUN immediately re-asserts reset and is recorded.
// Optional feature macro: LOSS_COUNTER_EN builds the saturating loss_count
// register. Without it, loss_count is tied to zero.
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   clear_lost,
  output logic                   reset_out,
  output logic                   ready,
  output logic                   lost_sticky,
  output logic [COUNT_WIDTH-1:0] loss_count
);

  // One counter serves both STABILIZE and HOLD, so it is sized for the longer phase
  localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             reset_out_q;
  logic             reset_out_d;
  logic             ready_q;
  logic             ready_d;
  logic             lost_sticky_q;
  logic             lost_sticky_d;
  logic             loss_event;

  // Two-flop synchronizer for the asynchronous lock flag; only s2 is consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= locked;
      s2_q <= s1_q;
    end
  end

  // State register together with the shared phase counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic: any sampled drop of lock sends the FSM back to WAIT_LOCK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (s2_q) begin
          state_d = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!s2_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!s2_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!s2_q) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs switch on the same edge as the state
  always_comb begin
    reset_out_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    loss_event  = (state_q == RUN) && !s2_q;
  end

  // Sticky loss flag; a loss on the same edge as a clear takes priority
  always_comb begin
    lost_sticky_d = lost_sticky_q;
    if (loss_event) begin
      lost_sticky_d = 1'b1;
    end else if (clear_lost) begin
      lost_sticky_d = 1'b0;
    end
  end

  // Sticky loss register
  always_ff @(posedge clock) begin
    if (reset) begin
      lost_sticky_q <= 1'b0;
    end else begin
      lost_sticky_q <= lost_sticky_d;
    end
  end

`ifdef LOSS_COUNTER_EN
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] loss_count_q;
  logic [COUNT_WIDTH-1:0] loss_count_d;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    sat_inc = (v == COUNT_MAX) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Loss counter next value: a loss coinciding with a clear restarts the count at one
  always_comb begin
    loss_count_d = loss_count_q;
    if (loss_event) begin
      loss_count_d = clear_lost ? COUNT_WIDTH'(1) : sat_inc(loss_count_q);
    end else if (clear_lost) begin
      loss_count_d = '0;
    end
  end

  // Loss counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_count_q <= '0;
    end else begin
      loss_count_q <= loss_count_d;
    end
  end

  assign loss_count = loss_count_q;
`else
  assign loss_count = '0;
`endif

  assign reset_out   = reset_out_q;
  assign ready       = ready_q;
  assign lost_sticky = lost_sticky_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor. The reference model tracks the
// run length of sampled lock (two edges late) and derives ready from it.
module tb_pll_lock_supervisor;

  localparam int S       = 8;
  localparam int H       = 4;
  localparam int CW      = 2;
  localparam int RUN_LEN = S + H + 1;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          locked;
  logic          clear_lost;
  logic          reset_out;
  logic          ready;
  logic          lost_sticky;
  logic [CW-1:0] loss_count;

  typedef struct {
    logic reset_out;
    logic ready;
    logic sticky;
    int   count;
  } exp_t;

  exp_t exp_q[$];
  bit   lock_hist[$];
  int   runlen   = 0;
  bit   m_sticky = 1'b0;
  int   m_count  = 0;
  int   checks   = 0;
  int   errors   = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .clear_lost (clear_lost),
    .reset_out  (reset_out),
    .ready      (ready),
    .lost_sticky(lost_sticky),
    .loss_count (loss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FSM sees the lock sample from two edges earlier; RUN is
  // reached once that delayed lock has been high for S+H+1 consecutive edges.
  task automatic model_edge(input bit rst, input bit lk, input bit clr);
    bit   v;
    bit   was_run;
    bit   loss;
    exp_t e;
    if (rst) begin
      lock_hist.delete();
      runlen   = 0;
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      v = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size()-2] : 1'b0;
      lock_hist.push_back(lk);
      if (lock_hist.size() > 4) void'(lock_hist.pop_front());
      was_run = (runlen >= RUN_LEN);
      if (v) runlen = (runlen < RUN_LEN) ? runlen + 1 : RUN_LEN;
      else   runlen = 0;
      loss = was_run && !v;
      if (loss)     m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
      if (loss)     m_count = clr ? 1 : ((m_count < CMAX) ? m_count + 1 : CMAX);
      else if (clr) m_count = 0;
    end
    e.ready     = (runlen >= RUN_LEN);
    e.reset_out = !e.ready;
    e.sticky    = m_sticky;
`ifdef LOSS_COUNTER_EN
    e.count     = m_count;
`else
    e.count     = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit rst, input bit lk, input bit clr);
    reset      = rst;
    locked     = lk;
    clear_lost = clr;
    @(posedge clock);
    #1;
    model_edge(rst, lk, clr);
  endtask

  // Counts edges from the first lock-high sample after reset until ready rises
  task automatic acquire_measure(input string name);
    int k;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (k < 0 && ready === 1'b1) k = i;
    end
    chk(name, k, 2 + S + H);
  endtask

  // Monitor: compare every output sample against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reset_out",   int'(reset_out),   int'(e.reset_out));
        chk("ready",       int'(ready),       int'(e.ready));
        chk("lost_sticky", int'(lost_sticky), int'(e.sticky));
        chk("loss_count",  int'(loss_count),  e.count);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    locked     = 1'b1;
    clear_lost = 1'b0;

    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    acquire_measure("acquire_from_reset");

    // Loss in RUN, then full relock
    repeat (4)  cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0);

    // Single-cycle glitch during STABILIZE restarts qualification
    repeat (3)  cycle(1'b0, 1'b0, 1'b0);
    repeat (7)  cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0);

    // Clear on the very edge of a loss event, then clear alone
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3)  cycle(1'b0, 1'b1, 1'b0);

    // Five loss/relock rounds drive the counter into saturation
    repeat (5) begin
      repeat (3)  cycle(1'b0, 1'b0, 1'b0);
      repeat (16) cycle(1'b0, 1'b1, 1'b0);
    end
    repeat (3) cycle(1'b0, 1'b1, 1'b0);

    // Reset pulse while in RUN, then reacquire
    cycle(1'b1, 1'b1, 1'b0);
    acquire_measure("reacquire_after_reset");

    // Randomized traffic: mostly-high lock with drops, occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 29) != 0),
            ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(negedge clock);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the PLL lock indication and generates the synchronous reset and ready status for all logic running in the 160 MHz pixel-clock domain. It runs on the PLL output clock and takes the PLL `locked` output as its asynchronous input. It releases downstream reset only after lock has been continuously stable and a reset hold period has elapsed. Any loss of lock immediately re-asserts downstream reset, and the block records the event for debug.

## Interface
- `STABLE_CYCLES`, 1024, consecutive synchronized-lock cycles required before the hold phase; must be ≥1.
- `HOLD_CYCLES`, 16, cycles downstream reset stays asserted after lock is qualified; must be ≥1.
- `COUNT_WIDTH`, 8, width of the lock-loss event counter.

- `clock`  in  1  PLL output clock (160 MHz); the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock flag; asynchronous to `clock`.
- `clear_lost`  in  1  single-cycle pulse; clears `lost_sticky` and `loss_count`.
- `reset_out`  out  1  registered active-high reset for the downstream 160 MHz domain.
- `ready`  out  1  registered; high only in RUN.
- `lost_sticky`  out  1  set on the first lock loss while in RUN.
- `loss_count`  out  COUNT_WIDTH  saturating count of lock losses seen while in RUN.

## Operation
- `locked` passes through a 2-flop synchronizer (`s1`, `s2`). Only `s2` is used.
- There is one down-counter-free up-counter. Its width is clog2(max(STABLE_CYCLES, HOLD_CYCLES)) and it is shared by the STABILIZE and HOLD states.
- FSM states and transitions:
  - WAIT_LOCK: `reset_out`=1, `ready`=0. If `s2`=1, go to STABILIZE with cnt=0.
  - STABILIZE: `reset_out`=1.
    - If `s2`=0, go to WAIT_LOCK. This is not counted as a loss.
    - Else if cnt==STABLE_CYCLES-1, go to HOLD with cnt=0.
    - Else cnt+1.
  - HOLD: `reset_out`=1.
    - If `s2`=0, go to WAIT_LOCK. This is not counted.
    - Else if cnt==HOLD_CYCLES-1, go to RUN.
    - Else cnt+1.
  - RUN: `reset_out`=0, `ready`=1. If `s2`=0, go to WAIT_LOCK, set `lost_sticky`, and increment `loss_count`.
- `reset_out` and `ready` are registered and decoded from the next state, so they change on the same edge as the state.
- `loss_count` saturates at 2^COUNT_WIDTH-1 and never wraps.
- `clear_lost` sets `lost_sticky`=0 and `loss_count`=0 on the next edge.
  - If a loss event occurs on the same edge, the event wins: `lost_sticky`=1 and `loss_count`=1.
- `clear_lost` has no effect on the FSM, `reset_out` or `ready`.

## Timing
- Reset values: FSM=WAIT_LOCK, `s1`=`s2`=0, cnt=0, `reset_out`=1, `ready`=0, `lost_sticky`=0, `loss_count`=0.
- Asserting `reset` in any state, including RUN, forces these values on the next edge. Sticky and counter values are also lost.
- Lock-acquire latency: let edge 0 be the first edge that samples `locked`=1.
  - FSM enters STABILIZE at edge 2.
  - FSM enters HOLD at edge 2+STABLE_CYCLES.
  - `ready`=1 and `reset_out`=0 after edge 2+STABLE_CYCLES+HOLD_CYCLES.
  - This requires `locked` to stay high throughout.
- Lock-loss latency: let edge m be the first edge that samples `locked`=0 while in RUN. Then `reset_out`=1, `ready`=0 and `lost_sticky`=1 take effect after edge m+2.
- Any `locked` low glitch of at least one sampled cycle during STABILIZE or HOLD restarts qualification from WAIT_LOCK.
- STABLE_CYCLES=1 and HOLD_CYCLES=1 are legal. Each phase then lasts exactly one cycle.

## Configuration
- `LOSS_COUNTER_EN` defined: the `loss_count` register and its saturation/clear logic are built as described above.
- `LOSS_COUNTER_EN` not defined: `loss_count` is tied to constant 0 and no counter flops exist. `lost_sticky`, the FSM and all timing are unchanged.

## Test plan
- Reset release with `locked`=1 from the start (STABLE=8, HOLD=4) -> `reset_out`=1 until edge 14, then `ready`=1 and `reset_out`=0; `lost_sticky`=0 and `loss_count`=0.
- `locked` drops for 1 cycle at edge 5 of STABILIZE (STABLE=8, HOLD=4) -> FSM returns to WAIT_LOCK, qualification restarts, `ready` is delayed accordingly, `loss_count` stays 0.
- In RUN, `locked` goes low at edge m -> `reset_out`=1 and `ready`=0 after edge m+2, `lost_sticky`=1, `loss_count`=1; relock produces `ready` again after the full 2+8+4 sequence.
- COUNT_WIDTH=2 with 5 loss/relock cycles -> `loss_count` saturates at 3.
- `clear_lost` pulsed on the same edge as a loss event -> `lost_sticky`=1, `loss_count`=1. `clear_lost` pulsed alone -> both return to 0.
- `reset` asserted for 1 cycle while in RUN -> all outputs at reset values on the next edge, then a normal reacquire with `ready` at edge 14.
